task7_stream_ctrl: RTL and testbench

Streaming front-end for the Task 7 datapath, which computes y = 0.5·x + x²·cos((x−128)/128). It accepts single-precision inputs over a valid/ready handshake and drives them into the fixed-latency, non-stallable datapath. It tags each in-flight sample, captures the datapath output at the correct cycle into an output FIFO, and presents results in order over a second valid/ready handshake. Credit-based admission ensures the FIFO never overflows, so the datapath never needs back-pressure.

---
 rtl/task7_stream_ctrl.sv | 127 ++++++++++++
 tb/tb_task7_stream_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/task7_stream_ctrl.sv
// Feeds a fixed-latency, non-stallable datapath (LATENCY cycles in to out) and queues results in a FWFT FIFO.
// Credit admission (occ < DEPTH) stalls only the input side; optional NaN/Inf bypass via TASK7_NAN_BYPASS_EN.

module task7_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          pop;

  // Write never checks for full: the caller's credit scheme guarantees room.
  always_comb begin
    rd_vld   = (wr_ptr_q != rd_ptr_q);
    rd_dat   = rd_vld ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    pop      = rd_vld && rd_rdy;
    wr_ptr_d = wr_vld ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end
endmodule

module task7_stream_ctrl #(
  parameter int LATENCY = 20,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] dp_data,
  input  logic [31:0] dp_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  logic [OW-1:0]      occ_q, occ_d;
  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [31:0]        dp_data_q, dp_data_d;
  logic               accept, pop, cap;
  logic [31:0]        cap_dat;

  // occ covers in-flight plus queued samples, so capture never changes it.
  always_comb begin
    in_ready  = (occ_q < OCC_MAX);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    cap       = vld_sr_q[LATENCY-1];
    vld_sr_d  = {vld_sr_q[LATENCY-2:0], accept};
    dp_data_d = accept ? in_data : dp_data_q;
    occ_d     = occ_q;
    if (accept && !pop)      occ_d = occ_q + OCC_ONE;
    else if (!accept && pop) occ_d = occ_q - OCC_ONE;
    busy      = (occ_q != '0);
  end

`ifdef TASK7_NAN_BYPASS_EN
  logic [LATENCY-1:0] nan_sr_q, nan_sr_d;

  always_comb begin
    nan_sr_d = {nan_sr_q[LATENCY-2:0], accept && (in_data[30:23] == 8'hFF)};
    cap_dat  = nan_sr_q[LATENCY-1] ? 32'h7FC0_0000 : dp_result;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) nan_sr_q <= '0;
    else          nan_sr_q <= nan_sr_d;
  end
`else
  always_comb cap_dat = dp_result;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q     <= '0;
      vld_sr_q  <= '0;
      dp_data_q <= '0;
    end else begin
      occ_q     <= occ_d;
      vld_sr_q  <= vld_sr_d;
      dp_data_q <= dp_data_d;
    end
  end

  assign dp_data = dp_data_q;

  task7_fifo #(.W(32), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (cap),
    .wr_dat  (cap_dat),
    .rd_rdy  (out_ready),
    .rd_vld  (out_valid),
    .rd_dat  (out_data)
  );
endmodule

// File: tb/tb_task7_stream_ctrl.sv
// Bench for task7_stream_ctrl with a behavioural float datapath (y = 0.5x + x^2 cos((x-128)/128)).
module tb_task7_stream_ctrl;
  localparam int LAT = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] dp_data, dp_result, out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  typedef struct { logic [31:0] y; int t; } ent_t;
  ent_t mq[$];
  typedef struct { logic [31:0] x; logic [31:0] y; } vec_t;
  vec_t tbl[6];

  logic [31:0] dp_pipe [LAT-1];

  always #5 clk = ~clk;

  task7_stream_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dp_data   (dp_data),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    int  e = int'(b[30:23]);
    real m = real'(b[22:0]) / 8388608.0;
    if (e == 0) m = m * pow2(-126);
    else        m = (1.0 + m) * pow2(e - 127);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic   s;
    real    a;
    int     e = 0;
    longint m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = longint'(a * 8388608.0);
    if (m >= 64'sd16777216) begin m = m >>> 1; e++; end
    if (e > 127)  return {s, 8'hFF, 23'h0};
    if (e < -126) return {s, 31'h0};
    return {s, 8'(e + 127), m[22:0]};
  endfunction

  // Stand-in datapath: NaN/Inf inputs come back with bit 0 flipped so a bypass is distinguishable.
  function automatic logic [31:0] dp_func(input logic [31:0] x);
    real xv;
    if (x[30:23] == 8'hFF) return x ^ 32'h1;
    xv = f2r(x);
    return r2f(0.5 * xv + xv * xv * $cos((xv - 128.0) / 128.0));
  endfunction

  function automatic logic [31:0] exp_y(input logic [31:0] x);
`ifdef TASK7_NAN_BYPASS_EN
    if (x[30:23] == 8'hFF) return 32'h7FC0_0000;
`endif
    return dp_func(x);
  endfunction

  function automatic logic [31:0] rndx();
    case ($urandom % 10)
      0:       return 32'h7F80_0000 | ($urandom & 32'h807F_FFFF);
      1:       return tbl[$urandom % 4].x;
      default: return {1'($urandom), 8'($urandom_range(112, 137)), 23'($urandom)};
    endcase
  endfunction

  always @(posedge clk) begin
    dp_pipe[0] <= dp_func(dp_data);
    for (int i = 1; i < LAT - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_result = dp_pipe[LAT-2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: a queue of results, each visible LAT edges after its accept.
  always @(negedge clk) begin
    bit   mv, rdy;
    ent_t e;
    if (reset_n && mon_en) begin
      mv  = (mq.size() > 0) && (mq[0].t <= cyc);
      rdy = (mq.size() < DEP);
      chk("mon_in_ready", 32'(in_ready), 32'(rdy));
      chk("mon_busy", 32'(busy), 32'(mq.size() != 0));
      chk("mon_out_valid", 32'(out_valid), 32'(mv));
      if (mv) chk("mon_out_data", out_data, mq[0].y);
      if (mv && out_ready) void'(mq.pop_front());
      if (in_valid && rdy) begin
        e.y = exp_y(in_data);
        e.t = cyc + 1 + LAT;
        mq.push_back(e);
      end
    end
    cyc++;
  end

  task automatic pulse_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    mq.delete();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_dp_data", dp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, acc, got, first, last, seen;
    logic [31:0] xq[$];

    tbl[0] = '{32'h4300_0000, 32'h4680_8000};
    tbl[1] = '{32'h0000_0000, 32'h0000_0000};
    tbl[2] = '{32'h3F80_0000, dp_func(32'h3F80_0000)};
    tbl[3] = '{32'h4000_0000, dp_func(32'h4000_0000)};
`ifdef TASK7_NAN_BYPASS_EN
    tbl[4] = '{32'h7F80_0000, 32'h7FC0_0000};
    tbl[5] = '{32'hFFC0_0001, 32'h7FC0_0000};
`else
    tbl[4] = '{32'h7F80_0000, 32'h7F80_0001};
    tbl[5] = '{32'hFFC0_0001, 32'hFFC0_0000};
`endif

    #3 pulse_reset();

    // Single samples from the table.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_data = tbl[i].x; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      chk("tbl_latency", 32'(lat), 32'(LAT));
      chk("tbl_data", out_data, tbl[i].y);
      @(negedge clk);
      chk("tbl_busy_idle", 32'(busy), 32'd0);
    end

    // Back-to-back stream of four.
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = tbl[(i + 1) % 4].x;
      @(negedge clk); chk("bb_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    got = 0; first = -1; last = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got < 4) chk("bb_data", out_data, tbl[(got + 1) % 4].y);
        if (got == 0) first = 3 + k;
        last = 3 + k;
        got++;
      end
    end
    chk("bb_count", 32'(got), 32'd4);
    chk("bb_first", 32'(first), 32'(LAT));
    chk("bb_contiguous", 32'(last - first), 32'd3);

    // Backpressure: out_ready low fills credits, one pop frees exactly one.
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_data = rndx();
    acc = 0;
    repeat (10) begin
      @(negedge clk); if (in_valid && in_ready) acc++;
      @(posedge clk); #1 in_data = rndx();
    end
    chk("bp_accepts", 32'(acc), 32'(DEP));
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    acc = 0;
    repeat (8) begin
      @(negedge clk); if (in_valid && in_ready) acc++;
      @(posedge clk); #1 in_data = rndx();
    end
    chk("bp_extra_accepts", 32'(acc), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("bp_drained", 32'(busy), 32'd0);

    // Continuous input with out_ready high: capture, accept and pop coincide.
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1;
    acc = 0; got = 0;
    for (int k = 0; k < 26; k++) begin
      if (k < 14) in_data = rndx();
      else        in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin xq.push_back(in_data); acc++; end
      if (out_valid && out_ready) begin
        chk("sim_order", out_data, exp_y(xq[0]));
        void'(xq.pop_front());
        got++;
      end
      @(posedge clk); #1;
    end
    chk("sim_count", 32'(got), 32'(acc));
    chk("sim_busy_idle", 32'(busy), 32'd0);

    // Reset with three samples in flight.
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1;
    repeat (3) begin in_data = rndx(); @(posedge clk); #1; end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy_before", 32'(busy), 32'd1);
    #2 pulse_reset();
    seen = 0;
    repeat (10) begin @(negedge clk); if (out_valid) seen++; end
    chk("rst_no_stale_out", 32'(seen), 32'd0);

    // Random traffic against the reference model.
    repeat (400) begin
      @(posedge clk); #1;
      in_valid  = (($urandom % 10) < 7);
      in_data   = rndx();
      out_ready = (($urandom % 10) < 6);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("rnd_busy_idle", 32'(busy), 32'd0);
    chk("rnd_out_valid_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
